dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Initiator side of the word-wide data-memory port. Sits in the MEM stage between the pipeline and the 256-word data memory.
- Converts byte/halfword/word loads and stores at byte addresses into word-indexed memory reads and writes. Sub-word stores use read-modify-write.
- Stalls the pipeline until each access completes. Returns aligned, extended load data.

Parameters:
- ADDR_BITS, 8, word-index width driven to memory (2**ADDR_BITS words).

Ports:
- clock  in  1  pipeline clock, rising-edge logic
- reset  in  1  asynchronous, active-high reset
- req_m  in  1  MEM-stage access request; held stable until done_m
- mem_write_m  in  1  1=store, 0=load
- size_m  in  2  00 byte, 01 half, 10 word, 11 treated as word
- signed_m  in  1  sign-extend sub-word loads
- alu_out_m  in  32  byte address
- write_data_m  in  32  store data, right-justified
- stall_m  out  1  hold pipeline
- done_m  out  1  one-cycle completion pulse
- read_data_m  out  32  load result, valid while done_m=1
- misalign_m  out  1  alignment fault, valid while done_m=1
- mem_addr  out  ADDR_BITS  word index = alu_out_m[ADDR_BITS+1:2]
- mem_wdata  out  32  word to write
- mem_we  out  1  memory write enable
- mem_rd  in  32  memory read data, valid one cycle after mem_addr presented with mem_we=0

Behaviour:
- Reset (async) values: state IDLE, all outputs and internal registers 0, mem_we deasserts immediately.
- States: IDLE, RD_ISSUE, RD_WAIT, WR, DONE.
  - DONE always returns to IDLE.
  - Requests are accepted only in IDLE.
- stall_m = req_m & ~done_m (combinational).
- All mem_* outputs and done_m/read_data_m/misalign_m are registered.
- Accept cycle T, IDLE with req_m=1; request fields are latched at T:
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to DONE. T+1: done_m=1, misalign_m=1, read_data_m=0, no memory access.
  - Load: RD_ISSUE at T+1 (mem_addr driven, mem_we=0). RD_WAIT at T+2 (mem_rd captured). DONE at T+3 with read_data_m. Latency 3.
  - Word store: WR at T+1 (mem_we=1, mem_wdata=write data). DONE at T+2. Latency 2.
  - Byte/half store: RD_ISSUE T+1, RD_WAIT T+2 (capture and merge), WR T+3 (mem_we=1 with merged word), DONE T+4. Latency 4.
- Lanes are little-endian: byte k = bits[8k+7:8k]. Half lane = addr[1]. Unselected lanes keep the captured word.
- Load extraction:
  - Byte and half are zero- or sign-extended per signed_m.
  - Word loads ignore signed_m.
- mem_we is high for exactly one cycle per store. It is never high for loads or misaligned accesses.
- Address bits above ADDR_BITS+1 are ignored, so out-of-range indices wrap modulo 2**ADDR_BITS.
- Dropping req_m mid-access does not abort the access; it completes and done_m still pulses.
- Reset mid-access aborts immediately with no partial write. A pending RMW write is never issued.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE, giving a minimum 1-cycle gap.

Optional Feature:
- Macro DMEM_LAST_WORD_CACHE_EN.
- Defined: one-entry cache holding a valid bit, a word index and a data word.
  - Filled on every RD_WAIT capture.
  - Updated with the written word on every WR.
  - Invalidated on reset.
  - Aligned loads that hit skip memory: DONE at T+1 with extracted data, no mem_addr change.
  - Sub-word stores that hit skip RD_ISSUE/RD_WAIT: WR at T+1, DONE at T+2.
- Undefined: no cache logic; all latencies as above.

Test Plan:
- Memory model preloaded MEM[x]=x. Word load at 0x14 -> mem_addr=5 at T+1; T+3 done_m=1, read_data_m=0x00000005; stall_m high T..T+2.
- Byte store 0xAB at 0x0D -> T+1 mem_addr=3, T+3 mem_we=1 with mem_wdata=0x0000AB03, done at T+4. Then signed byte load at 0x0D -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Half load at 0x0F -> T+1 done_m=1, misalign_m=1, read_data_m=0; mem_we stays 0 throughout.
- Half store 0x1234 at 0x0A; assert reset at T+2 -> mem_we never 1, state IDLE. A later word load at 0x08 returns 0x00000002.
- Word store 0xDEADBEEF at 0x3FC -> mem_addr=255 with mem_we=1 for one cycle at T+1, done at T+2. Word load at 0x400 -> mem_addr=0, data 0x00000000.
- With DMEM_LAST_WORD_CACHE_EN, word load 0x14 twice -> first completes T+3, second completes T+1 with 0x00000005 and no mem_addr activity.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline/memory bus of the MEM-stage data-memory access controller.
// master = pipeline + memory side, slave = dmem_access_ctrl.
interface dmem_access_ctrl_if #(
   parameter int ADDR_BITS = 8
);
   logic                 req_m;
   logic                 mem_write_m;
   logic [1:0]           size_m;
   logic                 signed_m;
   logic [31:0]          alu_out_m;
   logic [31:0]          write_data_m;
   logic                 stall_m;
   logic                 done_m;
   logic [31:0]          read_data_m;
   logic                 misalign_m;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [31:0]          mem_wdata;
   logic                 mem_we;
   logic [31:0]          mem_rd;

   modport master (
      output req_m, mem_write_m, size_m, signed_m, alu_out_m, write_data_m, mem_rd,
      input  stall_m, done_m, read_data_m, misalign_m, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      input  req_m, mem_write_m, size_m, signed_m, alu_out_m, write_data_m, mem_rd,
      output stall_m, done_m, read_data_m, misalign_m, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Byte/half/word load-store to word memory with RMW sub-word stores; stalls pipeline until done.
// Optional one-entry last-word cache: DMEM_LAST_WORD_CACHE_EN.
module dmem_access_ctrl #(
   parameter int ADDR_BITS = 8
) (
   input  logic              clock,
   input  logic              reset,
   dmem_access_ctrl_if.slave dmem
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_ISSUE = 3'd1,
      S_RD_WAIT  = 3'd2,
      S_WR       = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next;

   logic                 r_write;
   logic [1:0]           r_size;
   logic                 r_signed;
   logic [1:0]           r_lane;
   logic [ADDR_BITS-1:0] r_idx;
   logic [31:0]          r_wdata;

   logic                 r_done;
   logic [31:0]          r_rdata;
   logic                 r_misalign;
   logic [ADDR_BITS-1:0] r_mem_addr;
   logic [31:0]          r_mem_wdata;
   logic                 r_mem_we;

   logic                 w_done_nxt;
   logic [31:0]          w_rdata_nxt;
   logic                 w_mis_nxt;
   logic [ADDR_BITS-1:0] w_mem_addr_nxt;
   logic [31:0]          w_mem_wdata_nxt;
   logic                 w_mem_we_nxt;

   logic [ADDR_BITS-1:0] w_idx;
   logic [1:0]           w_lane;
   logic                 w_misalign;
   logic                 w_is_word;
   logic                 w_hit;
   logic [31:0]          w_cache_word;
   logic                 w_unused;

   assign w_idx      = dmem.alu_out_m[ADDR_BITS+1:2];
   assign w_lane     = dmem.alu_out_m[1:0];
   assign w_is_word  = dmem.size_m[1];
   assign w_misalign = (dmem.size_m == 2'b01) ? w_lane[0] : (w_is_word && (w_lane != 2'b00));
   assign w_unused   = ^dmem.alu_out_m[31:ADDR_BITS+2];

   function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   return {{24{sgn & b[7]}}, b};
         2'b01:   return {{16{sgn & h[15]}}, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [1:0] lane,
                                           input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] r;
      r = old;
      case (size)
         2'b00: r[{lane, 3'b000} +: 8] = wd[7:0];
         2'b01: if (lane[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

`ifdef DMEM_LAST_WORD_CACHE_EN
   logic                 r_c_vld;
   logic [ADDR_BITS-1:0] r_c_idx;
   logic [31:0]          r_c_dat;

   assign w_hit        = r_c_vld && (r_c_idx == w_idx);
   assign w_cache_word = r_c_dat;

   // Track whatever word last crossed the memory port, read or written.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_c_vld <= 1'b0;
         r_c_idx <= '0;
         r_c_dat <= '0;
      end else if (r_state == S_RD_WAIT) begin
         r_c_vld <= 1'b1;
         r_c_idx <= r_idx;
         r_c_dat <= dmem.mem_rd;
      end else if (r_state == S_WR) begin
         r_c_vld <= 1'b1;
         r_c_idx <= r_mem_addr;
         r_c_dat <= r_mem_wdata;
      end
   end
`else
   assign w_hit        = 1'b0;
   assign w_cache_word = '0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (dmem.req_m) begin
               if (w_misalign)                     w_next = S_DONE;
               else if (dmem.mem_write_m)          w_next = (w_is_word || w_hit) ? S_WR : S_RD_ISSUE;
               else                                w_next = w_hit ? S_DONE : S_RD_ISSUE;
            end
         end
         S_RD_ISSUE: w_next = S_RD_WAIT;
         S_RD_WAIT:  w_next = r_write ? S_WR : S_DONE;
         S_WR:       w_next = S_DONE;
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_mem_we_nxt    = (w_next == S_WR);
      w_done_nxt      = (w_next == S_DONE);
      w_rdata_nxt     = '0;
      w_mis_nxt       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (dmem.req_m) begin
               if (w_misalign) begin
                  w_mis_nxt = 1'b1;
               end else if (w_next == S_DONE) begin
                  w_rdata_nxt = f_extract(w_cache_word, w_lane, dmem.size_m, dmem.signed_m);
               end else begin
                  w_mem_addr_nxt = w_idx;
                  if (w_next == S_WR)
                     w_mem_wdata_nxt = f_merge(w_cache_word, w_lane, dmem.size_m, dmem.write_data_m);
               end
            end
         end
         S_RD_WAIT: begin
            if (r_write) w_mem_wdata_nxt = f_merge(dmem.mem_rd, r_lane, r_size, r_wdata);
            else         w_rdata_nxt     = f_extract(dmem.mem_rd, r_lane, r_size, r_signed);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_write  <= 1'b0;
         r_size   <= 2'b00;
         r_signed <= 1'b0;
         r_lane   <= 2'b00;
         r_idx    <= '0;
         r_wdata  <= '0;
      end else if ((r_state == S_IDLE) && dmem.req_m) begin
         r_write  <= dmem.mem_write_m;
         r_size   <= dmem.size_m;
         r_signed <= dmem.signed_m;
         r_lane   <= w_lane;
         r_idx    <= w_idx;
         r_wdata  <= dmem.write_data_m;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_done      <= 1'b0;
         r_rdata     <= '0;
         r_misalign  <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
      end else begin
         r_done      <= w_done_nxt;
         r_rdata     <= w_rdata_nxt;
         r_misalign  <= w_mis_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_we    <= w_mem_we_nxt;
      end
   end

   assign dmem.stall_m     = dmem.req_m & ~r_done;
   assign dmem.done_m      = r_done;
   assign dmem.read_data_m = r_rdata;
   assign dmem.misalign_m  = r_misalign;
   assign dmem.mem_addr    = r_mem_addr;
   assign dmem.mem_wdata   = r_mem_wdata;
   assign dmem.mem_we      = r_mem_we;

endmodule
